// File: rtl/button_debouncer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw, bouncing, asynchronous push-button into a clean debounced level
// and single-cycle press / release / long-press strobes. The button is
// synchronised on clk. It is only sampled on rising edges of the slow
// sample_tick square wave. A new level is accepted once STABLE_TICKS
// consecutive samples agree.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset (highest priority)
//   sample_tick   in   slow square wave from the divider, same clock domain;
//                      only its rising edge is used
//   btn_raw       in   asynchronous raw button
//   btn_level     out  debounced, normalised level (1 = pressed)
//   press_pulse   out  one-clk strobe on an accepted press
//   release_pulse out  one-clk strobe on an accepted release
//   long_press    out  one-clk strobe once the button has been held
//                      HOLD_TICKS ticks
//
// Optional feature (macro BUTTON_AUTOREPEAT_EN):
//   When the macro is defined, press_pulse re-fires every REPEAT_TICKS ticks
//   while the button stays held after long_press. When it is undefined, no
//   repeat logic exists and each accepted press gives exactly one press_pulse.
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 4096,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_TICKS = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int               CNT_W       = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS);
  localparam logic [15:0]      HOLD_LAST   = 16'(HOLD_TICKS);
  localparam logic             IDLE_LEVEL  = (ACTIVE_LOW != 0);

  // Parameter sanity checks, resolved at elaboration.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end
  if (STABLE_TICKS < 1 || STABLE_TICKS > 255) begin : g_bad_stable_ticks
    $error("STABLE_TICKS must be in 1..255");
  end
  if (HOLD_TICKS <= STABLE_TICKS || HOLD_TICKS > 65535) begin : g_bad_hold_ticks
    $error("HOLD_TICKS must exceed STABLE_TICKS and fit in 16 bits");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_bad_repeat_ticks
    $error("REPEAT_TICKS must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_PEND,
    ST_HELD,
    ST_RELEASE_PEND
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and tick edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tick_d;
  logic                   tick;
  logic                   btn_s;

  // The chain is preloaded with the idle level. This way, leaving reset
  // never looks like a press, whichever polarity the button uses.
  // NOTE: clocked state is always written with <= so that every flop samples
  // the pre-edge values of its neighbours; this is what makes the chain shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      tick_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      tick_d <= sample_tick;
    end
  end

  assign tick  = sample_tick & ~tick_d;
  assign btn_s = sync_q[SYNC_STAGES-1] ^ IDLE_LEVEL;

  // ---------------------------------------------------------------------------
  // Debounce state machine
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]      hold_q, hold_d;
  logic             press_d, release_d, long_d, level_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_TICKS);
  logic [15:0] rep_q, rep_d;
`endif

  always_comb begin
    // NOTE: every output of this block is given a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
    rep_d     = rep_q;
`endif

    if (tick) begin
      case (state_q)
        ST_RELEASED: begin
          if (btn_s) begin
            if (STABLE_TICKS == 1) begin
              state_d = ST_HELD;
              cnt_d   = '0;
              hold_d  = '0;
              press_d = 1'b1;
            end else begin
              state_d = ST_PRESS_PEND;
              cnt_d   = CNT_W'(1);
            end
          end
        end

        ST_PRESS_PEND: begin
          if (!btn_s) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_inc == STABLE_LAST) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            hold_d  = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_HELD: begin
          if (!btn_s) begin
            if (STABLE_TICKS == 1) begin
              state_d   = ST_RELEASED;
              cnt_d     = '0;
              hold_d    = '0;
              release_d = 1'b1;
            end else begin
              state_d = ST_RELEASE_PEND;
              cnt_d   = CNT_W'(1);
            end
          end else if (hold_q != HOLD_LAST) begin
            // hold_cnt is cleared on the entry tick and only counts on later
            // ticks. So long_press can never share a clk with the press strobe.
            hold_d = hold_q + 16'd1;
            long_d = ((hold_q + 16'd1) == HOLD_LAST);
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else begin
            // Saturated hold counter means long_press has already fired.
            if ((rep_q + 16'd1) == REPEAT_LAST) begin
              rep_d   = '0;
              press_d = 1'b1;
            end else begin
              rep_d = rep_q + 16'd1;
            end
          end
`endif
        end

        ST_RELEASE_PEND: begin
          // A high sample here is release bounce. Resume HELD with hold_cnt
          // intact, and do not issue another press strobe.
          if (btn_s) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_inc == STABLE_LAST) begin
            state_d   = ST_RELEASED;
            cnt_d     = '0;
            hold_d    = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
          hold_d  = '0;
        end
      endcase
    end

`ifdef BUTTON_AUTOREPEAT_EN
    if (state_d == ST_RELEASED) begin
      rep_d = '0;
    end
`endif

    level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_PEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RELEASED;
      cnt_q         <= '0;
      hold_q        <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer. Two instances share clk, reset and
// sample_tick: one is active-high and one is active-low. sample_tick has an
// 8-clk period and is high when (edge index % 8) < 4. Ticks therefore land on
// edges whose index is a multiple of 8.
//
// A value driven just after edge j reaches btn_s in time for edges >= j+3.
// The monitor tags each strobe and each level change with the index of the
// edge that registered it. Expected indices are written relative to the
// tick edge at which each stimulus starts.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset;
  logic sample_tick;
  logic btn_raw;
  logic btn_raw_al;
  logic btn_level, press_pulse, release_pulse, long_press;
  logic btn_level_al, press_pulse_al, release_pulse_al, long_press_al;

  int cyc         = -1;
  bit tick_freeze = 1'b0;
  int n_cmp       = 0;
  int n_bad       = 0;

  int press_q[$], release_q[$], long_q[$], rise_q[$], fall_q[$];
  int press_al_q[$], release_al_q[$], long_al_q[$], rise_al_q[$];
  logic level_prev    = 1'b0;
  logic level_al_prev = 1'b0;

  button_debouncer #(
    .SYNC_STAGES (2),
    .STABLE_TICKS(4),
    .HOLD_TICKS  (16),
    .ACTIVE_LOW  (0),
    .REPEAT_TICKS(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  button_debouncer #(
    .SYNC_STAGES (2),
    .STABLE_TICKS(4),
    .HOLD_TICKS  (16),
    .ACTIVE_LOW  (1),
    .REPEAT_TICKS(4)
  ) dut_al (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .btn_raw      (btn_raw_al),
    .btn_level    (btn_level_al),
    .press_pulse  (press_pulse_al),
    .release_pulse(release_pulse_al),
    .long_press   (long_press_al)
  );

  always #5 clk = ~clk;

  // Edge counter and sample_tick generator (value for edge k is driven after edge k-1).
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (!tick_freeze) sample_tick = ((cyc + 1) % 8) < 4;
    end
  end

  // Strobe / level monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (press_pulse)      press_q.push_back(cyc);
    if (release_pulse)    release_q.push_back(cyc);
    if (long_press)       long_q.push_back(cyc);
    if (btn_level && !level_prev) rise_q.push_back(cyc);
    if (!btn_level && level_prev) fall_q.push_back(cyc);
    if (press_pulse_al)   press_al_q.push_back(cyc);
    if (release_pulse_al) release_al_q.push_back(cyc);
    if (long_press_al)    long_al_q.push_back(cyc);
    if (btn_level_al && !level_al_prev) rise_al_q.push_back(cyc);
    level_prev    <= btn_level;
    level_al_prev <= btn_level_al;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time budget exhausted at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance to just after the next tick edge (edge index a multiple of 8).
  task automatic align();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % 8 != 0);
  endtask

  task automatic clear_q();
    press_q.delete();
    release_q.delete();
    long_q.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  initial begin
    int t;
    reset       = 1'b1;
    btn_raw     = 1'b0;
    btn_raw_al  = 1'b1;
    sample_tick = 1'b1;

    // Reset held over edges 0..3.
    step(4);
    reset = 1'b0;
    check("rst_outputs",    32'({btn_level, press_pulse, release_pulse, long_press}), 0);
    check("rst_outputs_al", 32'({btn_level_al, press_pulse_al, release_pulse_al, long_press_al}), 0);
    step(20);
    check("idle_no_press", press_q.size(), 0);

    // Clean press followed by a long hold. Ticks at t+8..t+32 qualify the
    // press, which is registered at t+32. HELD counts t+40..t+160, so
    // long_press fires at t+160. The release is driven at t+272; the low
    // samples fall at t+280..t+304, so the release is registered at t+304.
    clear_q();
    align();
    t = cyc;
    btn_raw = 1'b1;
    step(272);
    btn_raw = 1'b0;
    step(48);
    check("a_press_at",    (press_q.size() > 0) ? press_q[0] : -1, t + 32);
    check("a_level_rise",  (rise_q.size() > 0) ? rise_q[0] : -1, t + 32);
    check("a_long_count",  long_q.size(), 1);
    check("a_long_at",     (long_q.size() > 0) ? long_q[0] : -1, t + 160);
`ifdef BUTTON_AUTOREPEAT_EN
    check("a_press_count", press_q.size(), 4);
    check("a_repeat1_at",  (press_q.size() > 1) ? press_q[1] : -1, t + 192);
    check("a_repeat2_at",  (press_q.size() > 2) ? press_q[2] : -1, t + 224);
    check("a_repeat3_at",  (press_q.size() > 3) ? press_q[3] : -1, t + 256);
`else
    check("a_press_count", press_q.size(), 1);
`endif
    check("a_release_at",  (release_q.size() > 0) ? release_q[0] : -1, t + 304);
    check("a_level_fall",  (fall_q.size() > 0) ? fall_q[0] : -1, t + 304);

    // Bounce: toggle every 3 clk from t (first drive 1) up to t+39, then
    // drive a steady 1 from t+42. Tick samples: t+8=0, t+16=1, t+24=0,
    // t+32=0, t+40=1 (from the t+36 drive), t+48..=1. The press is
    // therefore registered at t+64.
    clear_q();
    align();
    t = cyc;
    btn_raw = 1'b1;
    for (int i = 1; i < 14; i++) begin
      step(3);
      btn_raw = (i % 2 == 0);
    end
    step(3);
    btn_raw = 1'b1;
    step(38);
    check("b_press_count",   press_q.size(), 1);
    check("b_press_at",      (press_q.size() > 0) ? press_q[0] : -1, t + 64);
    check("b_release_count", release_q.size(), 0);

    // Release bounce from HELD: low from t, high from t+16, low from t+24.
    // Ticks t+8,t+16 are low, t+24 is high, t+32..t+56 are low. The
    // release is registered at t+56, with no new press strobe.
    clear_q();
    align();
    t = cyc;
    btn_raw = 1'b0;
    step(16);
    btn_raw = 1'b1;
    step(8);
    btn_raw = 1'b0;
    step(40);
    check("c_press_count",   press_q.size(), 0);
    check("c_release_count", release_q.size(), 1);
    check("c_release_at",    (release_q.size() > 0) ? release_q[0] : -1, t + 56);
    check("c_level_fall",    (fall_q.size() > 0) ? fall_q[0] : -1, t + 56);
    check("c_long_count",    long_q.size(), 0);

    // Reset mid-hold. The press is registered at t+32. Reset is sampled at
    // t+40, which is also a tick edge, and that tick is ignored. tick_d
    // restarts at 0, so t+41 ticks, but it sees the idle sync chain. The
    // re-qualification ticks are t+48..t+72, so the new press is
    // registered at t+72. The release drive at t+80 is registered at t+112.
    clear_q();
    align();
    t = cyc;
    btn_raw = 1'b1;
    step(39);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("d_rst_outputs", 32'({btn_level, press_pulse, release_pulse, long_press}), 0);
    step(40);
    btn_raw = 1'b0;
    step(40);
    check("d_level_fall_rst", (fall_q.size() > 0) ? fall_q[0] : -1, t + 40);
    check("d_press_count",    press_q.size(), 2);
    check("d_press1_at",      (press_q.size() > 0) ? press_q[0] : -1, t + 32);
    check("d_press2_at",      (press_q.size() > 1) ? press_q[1] : -1, t + 72);
    check("d_release_count",  release_q.size(), 1);
    check("d_release_at",     (release_q.size() > 0) ? release_q[0] : -1, t + 112);

    // sample_tick frozen high: a pressed button must not be seen.
    clear_q();
    align();
    tick_freeze = 1'b1;
    btn_raw = 1'b1;
    step(100);
    btn_raw = 1'b0;
    step(10);
    check("f_frozen_press",  press_q.size(), 0);
    check("f_frozen_level",  32'(btn_level), 0);
    tick_freeze = 1'b0;
    step(24);
    check("f_resume_strobes", press_q.size() + release_q.size() + long_q.size(), 0);

    // Active-low instance: quiet for the whole run so far, including reset.
    check("e_al_idle_strobes", press_al_q.size() + release_al_q.size() + long_al_q.size(), 0);
    check("e_al_idle_level",   32'(btn_level_al), 0);
    // Press (drive 0) at t gives press at t+32. Idle (drive 1) at t+40 gives
    // release at t+72.
    align();
    t = cyc;
    btn_raw_al = 1'b0;
    step(40);
    btn_raw_al = 1'b1;
    step(40);
    check("e_al_press_count", press_al_q.size(), 1);
    check("e_al_press_at",    (press_al_q.size() > 0) ? press_al_q[0] : -1, t + 32);
    check("e_al_level_rise",  (rise_al_q.size() > 0) ? rise_al_q[0] : -1, t + 32);
    check("e_al_release_at",  (release_al_q.size() > 0) ? release_al_q[0] : -1, t + 72);
    check("e_al_long_count",  long_al_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Consumer end of the divider's debounce tick: turns a raw, bouncing, asynchronous push-button into clean single-cycle strobes.
- Samples the button only on rising edges of the slow `sample_tick` square wave (100us period at 2.5MHz).
- Requires a level to be stable for STABLE_TICKS samples before it is accepted.
- `press_pulse` drives the clock/enable of the quad state stepper; `long_press` flags a held button.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising `btn_raw` (minimum 2).
- STABLE_TICKS, 4, consecutive equal samples needed to accept a level change (range 1..255).
- HOLD_TICKS, 4096, ticks in the held state before `long_press` fires (must be > STABLE_TICKS; range up to 2^16-1).
- ACTIVE_LOW, 0, 1 = the button reads 0 when pressed.
- REPEAT_TICKS, 1024, auto-repeat interval in ticks (used only with AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  divider square wave, same clock domain; only its rising edge is used.
- btn_raw  in  1  asynchronous raw button.
- btn_level  out  1  debounced, normalised level (1 = pressed).
- press_pulse  out  1  one-clk strobe on accepted press.
- release_pulse  out  1  one-clk strobe on accepted release.
- long_press  out  1  one-clk strobe when HOLD_TICKS is reached.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high. Reset has priority over every other event.
- Reset values:
  - All outputs 0; state RELEASED; all counters 0.
  - tick_d = 0.
  - Sync chain loaded with the inactive level (= ACTIVE_LOW).
- Tick detect: `tick = sample_tick & ~tick_d`; tick_d is `sample_tick` registered. No other activity depends on `sample_tick`.
- Synchroniser: btn_s = last sync stage XOR ACTIVE_LOW. This value is sampled in the tick cycle.
- State machine (transitions only in tick cycles; all counters hold between ticks):
  - RELEASED: btn_s=1 -> PRESS_PEND, cnt=1. If STABLE_TICKS=1, go directly to HELD instead.
  - PRESS_PEND:
    - btn_s=0 -> RELEASED, cnt=0.
    - Else cnt+1. On reaching STABLE_TICKS -> HELD; press_pulse=1 next clk; hold_cnt=0.
  - HELD:
    - btn_s=0 -> RELEASE_PEND, cnt=1.
    - Else hold_cnt increments, saturating at HOLD_TICKS. On the tick where it becomes HOLD_TICKS, long_press=1 next clk, exactly once per press.
  - RELEASE_PEND:
    - btn_s=1 -> HELD, cnt=0. hold_cnt is kept, not cleared, and no new press_pulse is issued (bounce on release).
    - Else cnt+1. On reaching STABLE_TICKS -> RELEASED; release_pulse=1 next clk.
    - If STABLE_TICKS=1, the release completes on the first low sample.
- Outputs are registered. btn_level=1 in HELD and RELEASE_PEND. All strobes are exactly 1 clk wide.
- Latency from a clean btn_raw edge to the strobe: SYNC_STAGES clks to btn_s, + STABLE_TICKS ticks, + 1 clk.
- Counter widths: cnt is clog2(STABLE_TICKS+1) bits; hold_cnt is 16 bits. Neither counter wraps.
- Boundary cases:
  - Reset mid-press: return to RELEASED with no release_pulse. A still-held button must re-qualify (STABLE_TICKS samples) and yields a fresh press_pulse.
  - Tick in the reset cycle is ignored.
  - `sample_tick` held constant: no state change indefinitely.
  - press_pulse and long_press never assert in the same clk. If HOLD_TICKS were reachable on the entry tick, long_press is deferred to the next tick.

Optional Feature:
- Macro BUTTON_AUTOREPEAT_EN, when defined:
  - After long_press, while in HELD, press_pulse re-fires every REPEAT_TICKS ticks. The first repeat comes REPEAT_TICKS ticks after long_press.
  - The repeat counter freezes in RELEASE_PEND and clears on RELEASED or reset.
- When undefined: no repeat logic is synthesised; exactly one press_pulse per accepted press.

Test Plan:
- Common setup: sample_tick period 8 clk (4 high / 4 low), STABLE_TICKS=4, HOLD_TICKS=16, REPEAT_TICKS=4, SYNC_STAGES=2.
- Clean press: btn_raw 0->1 held 200 clk -> exactly one press_pulse. It comes 1 clk after the 4th tick following sync; btn_level=1 from the same clk.
- Bounce: btn_raw toggles every 3 clk for 40 clk, then is steady 1 -> no strobes during bouncing; one press_pulse 4 ticks after the last toggle.
- Release bounce: from HELD, drive 0 for 2 ticks, 1 for 1 tick, then steady 0 -> no press_pulse re-issued; one release_pulse after 4 consecutive low ticks; btn_level drops with it.
- Long hold: hold for 30 ticks -> long_press once, at 16 ticks after entering HELD.
  - With BUTTON_AUTOREPEAT_EN: additional press_pulses at +4, +8, +12 ticks.
  - Without it: none.
- Reset mid-hold: assert reset 1 clk while in HELD with btn_raw=1 -> outputs 0, no release_pulse; a new press_pulse arrives after 4 ticks + sync.
- ACTIVE_LOW=1: btn_raw idle 1, pressed 0 -> same strobe timing as the clean-press case; no strobe out of reset.
